// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with configurable frame format.
// Received bytes and their parity/framing flags go into a small FIFO with a valid/ready output.
module uart_rx_fifo #(
   parameter int CLK_DIV    = 27,
   parameter int OVS        = 16,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rxd,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          overrun,
   input  logic                          clr_overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SCNT_W = $clog2(OVS);
   localparam int BCNT_W = $clog2(DATA_BITS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int ENT_W  = DATA_BITS + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   logic [1:0]           sync_q, sync_d;
   logic [DIV_W-1:0]     div_q, div_d;
   state_t               state_q, state_d;
   logic [SCNT_W-1:0]    scnt_q, scnt_d;
   logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 pen_q, pen_d;
   logic                 podd_q, podd_d;
   logic                 perr_q, perr_d;
   logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 overrun_q, overrun_d;

   logic                 rxd_s;
   logic                 tick;
   logic                 scnt_last;
   logic                 push_req;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic [ENT_W-1:0]     push_entry;

   always_comb begin
      sync_d = {sync_q[0], rxd};
      rxd_s  = sync_q[1];
      tick   = (div_q == DIV_W'(CLK_DIV - 1));
      div_d  = tick ? '0 : div_q + DIV_W'(1);
   end

   // Frame FSM; everything advances only on oversample ticks.
   always_comb begin
      state_d    = state_q;
      scnt_d     = scnt_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      pen_d      = pen_q;
      podd_d     = podd_q;
      perr_d     = perr_q;
      push_req   = 1'b0;
      scnt_last  = (scnt_q == SCNT_W'(OVS - 1));
      push_entry = {~rxd_s, perr_q, shift_q};
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxd_s) begin
                  state_d = S_START;
                  scnt_d  = '0;
               end
            end
            S_START: begin
               if (scnt_q == SCNT_W'(OVS / 2 - 1)) begin
                  pen_d  = parity_en;
                  podd_d = parity_odd;
                  perr_d = 1'b0;
                  if (!rxd_s) begin
                     state_d = S_DATA;
                     scnt_d  = '0;
                     bcnt_d  = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  scnt_d = scnt_q + SCNT_W'(1);
               end
            end
            S_DATA: begin
               if (scnt_last) begin
                  scnt_d  = '0;
                  shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                  if (bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
                     state_d = pen_q ? S_PARITY : S_STOP;
                  end else begin
                     bcnt_d = bcnt_q + BCNT_W'(1);
                  end
               end else begin
                  scnt_d = scnt_q + SCNT_W'(1);
               end
            end
            S_PARITY: begin
               if (scnt_last) begin
                  scnt_d  = '0;
                  perr_d  = ((^shift_q) ^ rxd_s) != podd_q;
                  state_d = S_STOP;
               end else begin
                  scnt_d = scnt_q + SCNT_W'(1);
               end
            end
            S_STOP: begin
               if (scnt_last) begin
                  push_req = 1'b1;
                  state_d  = rxd_s ? S_IDLE : S_BREAK;
               end else begin
                  scnt_d = scnt_q + SCNT_W'(1);
               end
            end
            S_BREAK: begin
               if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A full FIFO still takes a frame when the head leaves on the same edge.
   always_comb begin
      pop       = rx_valid & rx_ready;
      full      = (level_q == LVL_W'(FIFO_DEPTH));
      push      = push_req & (~full | pop);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      overrun_d = overrun_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
      if (push_req && !push) overrun_d = 1'b1;
      else if (clr_overrun) overrun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         div_q     <= '0;
         state_q   <= S_IDLE;
         scnt_q    <= '0;
         bcnt_q    <= '0;
         shift_q   <= '0;
         pen_q     <= 1'b0;
         podd_q    <= 1'b0;
         perr_q    <= 1'b0;
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         div_q     <= div_d;
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         bcnt_q    <= bcnt_d;
         shift_q   <= shift_d;
         pen_q     <= pen_d;
         podd_q    <= podd_d;
         perr_q    <= perr_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_valid                     = (level_q != '0);
   assign {rx_ferr, rx_perr, rx_data}  = mem_q[rd_ptr_q];
   assign overrun                      = overrun_q;
   assign fifo_level                   = level_q;

endmodule
